// File: rtl/voter_pkg.sv
// Shared types and width helpers for the N-modular-redundancy voter family.
package voter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VOTE    = 2'd2
  } state_t;

  localparam int N_CH_DEF      = 4;
  localparam int FAULT_LIM_DEF = 3;

  // Widths for the default configuration; parametrised users call the helpers.
  localparam int CNT_W  = $clog2(N_CH_DEF + 1);
  localparam int FCNT_W = $clog2(FAULT_LIM_DEF + 1);

  function automatic int cnt_width(input int n_ch);
    return $clog2(n_ch + 1);
  endfunction

  function automatic int fcnt_width(input int fault_lim);
    return $clog2(fault_lim + 1);
  endfunction

endpackage

// File: rtl/voter_tally.sv
// Combinational plurality tally: counts identical words among eligible channels,
// picks the largest group (lowest channel index on ties) and flags its members.
module voter_tally #(
  parameter int N_CH = 4,
  parameter int W    = 1,
  parameter int CW   = $clog2(N_CH + 1)
) (
  input  logic [N_CH*W-1:0] data,
  input  logic [N_CH-1:0]   valid,
  input  logic [N_CH-1:0]   healthy,
  output logic [W-1:0]      winner,
  output logic [CW-1:0]     count,
  output logic [N_CH-1:0]   match
);

  logic [N_CH-1:0] elig;

  assign elig = valid & healthy;

  always_comb begin : tally
    logic [CW-1:0] c;
    // NOTE: every variable gets a default before the loops so no path can infer a latch.
    winner = '0;
    count  = '0;
    match  = '0;
    c      = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (elig[i]) begin
        c = '0;
        for (int j = 0; j < N_CH; j++) begin
          if (elig[j] && (data[j*W +: W] == data[i*W +: W])) c = c + 1'b1;
        end
        // Strict '>' keeps the earliest channel when counts tie.
        if (c > count) begin
          count  = c;
          winner = data[i*W +: W];
        end
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      match[i] = elig[i] && (count != '0) && (data[i*W +: W] == winner);
    end
  end

endmodule

// File: rtl/voter_nmr.sv
// N-modular-redundancy voter: collects one sample per channel per round, votes
// against a threshold and locks out channels that keep disagreeing or going silent.
module voter_nmr
  import voter_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int W         = 1,
  parameter int THRESH    = 3,
  parameter int TIMEOUT   = 15,
  parameter int FAULT_LIM = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            ch_valid,
  input  logic [N_CH*W-1:0]          ch_data,
  input  logic                       clr_fault,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  output logic                       out_agree,
  output logic [$clog2(N_CH+1)-1:0]  out_count,
  output logic [N_CH-1:0]            dis_mask,
  output logic [N_CH-1:0]            fault_mask
);

  localparam int CW = cnt_width(N_CH);
  localparam int FW = fcnt_width(FAULT_LIM);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [N_CH-1:0]   cap_valid;
  logic [N_CH*W-1:0] cap_data;
  logic [TW-1:0]     timer;
  logic [FW-1:0]     fcnt [N_CH];

  logic [N_CH-1:0]   healthy;
  logic [N_CH-1:0]   new_cap;
  logic              all_cap;
  logic [W-1:0]      t_winner;
  logic [CW-1:0]     t_count;
  logic [N_CH-1:0]   t_match;
  logic              agree;
  logic [N_CH-1:0]   dis;
  logic              capturing;

  assign healthy   = ~fault_mask;
  // Only the first strobe of a round per healthy channel is taken; VOTE drops strobes.
  assign capturing = (state == IDLE) || (state == COLLECT);
  assign new_cap   = capturing ? (ch_valid & healthy & ~cap_valid) : '0;
  assign all_cap   = &(cap_valid | new_cap | fault_mask);
  assign agree     = (t_count >= CW'(THRESH));
  assign dis       = healthy & ~t_match;

  voter_tally #(
    .N_CH (N_CH),
    .W    (W),
    .CW   (CW)
  ) u_tally (
    .data    (cap_data),
    .valid   (cap_valid),
    .healthy (healthy),
    .winner  (t_winner),
    .count   (t_count),
    .match   (t_match)
  );

  // NOTE: sample storage has no reset; cap_valid alone decides whether a word is used.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (new_cap[i]) cap_data[i*W +: W] <= ch_data[i*W +: W];
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cap_valid  <= '0;
      timer      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_agree  <= 1'b0;
      out_count  <= '0;
      dis_mask   <= '0;
      fault_mask <= '0;
      for (int i = 0; i < N_CH; i++) fcnt[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|new_cap) begin
            cap_valid <= new_cap;
            timer     <= '0;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          cap_valid <= cap_valid | new_cap;
          timer     <= timer + 1'b1;
          if (all_cap || (timer == TW'(TIMEOUT - 1))) state <= VOTE;
        end
        VOTE: begin
          out_valid <= 1'b1;
          out_agree <= agree;
          out_count <= t_count;
          if (agree) begin
            out_data <= t_winner;
            dis_mask <= dis;
            for (int i = 0; i < N_CH; i++) begin
              if (dis[i]) begin
                if (fcnt[i] < FW'(FAULT_LIM)) fcnt[i] <= fcnt[i] + 1'b1;
                if (fcnt[i] >= FW'(FAULT_LIM - 1)) fault_mask[i] <= 1'b1;
              end else if (t_match[i]) begin
                fcnt[i] <= '0;
              end
            end
          end else begin
            dis_mask <= '0;
          end
          cap_valid <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Placed last so a clear overrides any counter update on the same edge.
      if (clr_fault) begin
        fault_mask <= '0;
        for (int i = 0; i < N_CH; i++) fcnt[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_voter_nmr.sv
// Directed self-checking bench for voter_nmr: a 4x1-bit voter plus two 8-bit
// configurations for plurality and tie-break checks.
module tb_voter_nmr;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  always #5 clk = ~clk;

  // 4 channels, 1 bit, THRESH 3
  logic [3:0] v4, d4, dm4, fm4;
  logic       ov4, od4, oa4;
  logic [2:0] oc4;

  // 5 channels, 8 bits, THRESH 3
  logic [4:0]  v5, dm5, fm5;
  logic [39:0] d5;
  logic        ov5, oa5;
  logic [7:0]  od5;
  logic [2:0]  oc5;

  // 4 channels, 8 bits, THRESH 2 (tie-break)
  logic [3:0]  vt, dmt, fmt;
  logic [31:0] dt;
  logic        ovt, oat;
  logic [7:0]  odt;
  logic [2:0]  oct;

  int passed = 0;
  int total  = 0;

  voter_nmr #(.N_CH(4), .W(1), .THRESH(3), .TIMEOUT(15), .FAULT_LIM(3)) dut4 (
    .clk(clk), .rst(rst), .ch_valid(v4), .ch_data(d4), .clr_fault(clr),
    .out_valid(ov4), .out_data(od4), .out_agree(oa4), .out_count(oc4),
    .dis_mask(dm4), .fault_mask(fm4)
  );

  voter_nmr #(.N_CH(5), .W(8), .THRESH(3), .TIMEOUT(15), .FAULT_LIM(3)) dut5 (
    .clk(clk), .rst(rst), .ch_valid(v5), .ch_data(d5), .clr_fault(clr),
    .out_valid(ov5), .out_data(od5), .out_agree(oa5), .out_count(oc5),
    .dis_mask(dm5), .fault_mask(fm5)
  );

  voter_nmr #(.N_CH(4), .W(8), .THRESH(2), .TIMEOUT(15), .FAULT_LIM(3)) dutt (
    .clk(clk), .rst(rst), .ch_valid(vt), .ch_data(dt), .clr_fault(clr),
    .out_valid(ovt), .out_data(odt), .out_agree(oat), .out_count(oct),
    .dis_mask(dmt), .fault_mask(fmt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one dut4 round; lat = edges after the capture edge until out_valid.
  task automatic run4(input logic [3:0] v, input logic [3:0] d, output int lat);
    v4 = v;
    d4 = d;
    step();
    v4 = '0;
    lat = 0;
    while (ov4 !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic res4(input string tag, input int lat, input int elat,
                      input logic ed, input logic ea, input logic [2:0] ec,
                      input logic [3:0] edm, input logic [3:0] efm);
    check({tag, ".lat"},   lat, elat);
    check({tag, ".data"},  od4, ed);
    check({tag, ".agree"}, oa4, ea);
    check({tag, ".count"}, oc4, ec);
    check({tag, ".dis"},   dm4, edm);
    check({tag, ".fault"}, fm4, efm);
    step();
    check({tag, ".pulse"}, ov4, 1'b0);
  endtask

  task automatic quiet4(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (ov4 === 1'b1) seen = 1'b1;
    end
    check(tag, seen, 1'b0);
  endtask

  initial begin
    int lat;
    rst = 1'b1; clr = 1'b0;
    v4 = '0; d4 = '0; v5 = '0; d5 = '0; vt = '0; dt = '0;
    repeat (2) step();
    rst = 1'b0;

    check("rst.valid", ov4, 1'b0);
    check("rst.data",  od4, 1'b0);
    check("rst.agree", oa4, 1'b0);
    check("rst.count", oc4, 3'd0);
    check("rst.dis",   dm4, 4'b0000);
    check("rst.fault", fm4, 4'b0000);

    // ch3 disagrees: 2-cycle latency, ch3 counter -> 1
    run4(4'b1111, 4'b0111, lat);
    res4("t1", lat, 2, 1'b1, 1'b1, 3'd3, 4'b1000, 4'b0000);

    // 2-2 split: no agreement, counters untouched
    run4(4'b1111, 4'b0011, lat);
    res4("t2", lat, 2, 1'b1, 1'b0, 3'd2, 4'b0000, 4'b0000);

    // ch3 silent: vote after timeout, counter 2 then 3 (locked)
    run4(4'b0111, 4'b0111, lat);
    res4("t3", lat, 16, 1'b1, 1'b1, 3'd3, 4'b1000, 4'b0000);
    run4(4'b0111, 4'b0111, lat);
    res4("t4", lat, 16, 1'b1, 1'b1, 3'd3, 4'b1000, 4'b1000);

    // ch3 locked out: round completes without waiting for it
    run4(4'b0111, 4'b0111, lat);
    res4("t5", lat, 2, 1'b1, 1'b1, 3'd3, 4'b0000, 4'b1000);

    // strobe on faulted channel only: no round
    v4 = 4'b1000; d4 = 4'b1111;
    step();
    v4 = '0;
    quiet4("t6.noround", 20);

    // winner 0 with count 2 < 3: out_data holds 1
    run4(4'b0111, 4'b0100, lat);
    res4("t7", lat, 2, 1'b1, 1'b0, 3'd2, 4'b0000, 4'b1000);

    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t8.clr", fm4, 4'b0000);

    run4(4'b1111, 4'b0000, lat);
    res4("t9", lat, 2, 1'b0, 1'b1, 3'd4, 4'b0000, 4'b0000);

    // ch0 dissents while clr_fault is held: its counter stays 0
    clr = 1'b1;
    run4(4'b1111, 4'b0001, lat);
    clr = 1'b0;
    res4("t10a", lat, 2, 1'b0, 1'b1, 3'd3, 4'b0001, 4'b0000);
    run4(4'b1111, 4'b0001, lat);
    res4("t10b", lat, 2, 1'b0, 1'b1, 3'd3, 4'b0001, 4'b0000);
    run4(4'b1111, 4'b0001, lat);
    res4("t10c", lat, 2, 1'b0, 1'b1, 3'd3, 4'b0001, 4'b0000);
    run4(4'b1111, 4'b0001, lat);
    res4("t10d", lat, 2, 1'b0, 1'b1, 3'd3, 4'b0001, 4'b0001);

    // reset in the 5th COLLECT cycle abandons the round
    v4 = 4'b0111; d4 = 4'b0111;
    step();
    v4 = '0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t11.valid", ov4, 1'b0);
    check("t11.agree", oa4, 1'b0);
    check("t11.count", oc4, 3'd0);
    check("t11.dis",   dm4, 4'b0000);
    check("t11.fault", fm4, 4'b0000);
    quiet4("t11.noround", 20);

    run4(4'b1111, 4'b0111, lat);
    res4("t12", lat, 2, 1'b1, 1'b1, 3'd3, 4'b1000, 4'b0000);

    // 8-bit plurality and tie-break, both instances in one round
    v5 = 5'b11111; d5 = {8'h3C, 8'hA5, 8'h3C, 8'hA5, 8'hA5};
    vt = 4'b1111;  dt = {8'h3C, 8'hA5, 8'hA5, 8'h3C};
    step();
    v5 = '0; vt = '0;
    lat = 0;
    while (ov5 !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    check("w.lat",    lat, 2);
    check("w5.data",  od5, 8'hA5);
    check("w5.agree", oa5, 1'b1);
    check("w5.count", oc5, 3'd3);
    check("w5.dis",   dm5, 5'b10100);
    check("wt.valid", ovt, 1'b1);
    check("wt.data",  odt, 8'h3C);
    check("wt.agree", oat, 1'b1);
    check("wt.count", oct, 3'd2);
    check("wt.dis",   dmt, 4'b0110);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
